// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - run controller for a programmable serial pattern detector
//
// Holds a shadow copy of the detector configuration and sequences one
// detection run over a bounded (cfg_window != 0) or unbounded window of
// valid serial bits, counting pattern matches.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   cfg_we         load cfg_* into the shadow registers (IDLE only)
//   cfg_pattern    pattern, bit[len-1] arrives first, bit[0] last
//   cfg_len        pattern length, 1..MAXLEN
//   cfg_overlap    1 = overlapping matches, 0 = non-overlapping
//   cfg_window     valid bits per run, 0 = unbounded
//   start          begin a run (IDLE only)
//   abort          end the current run immediately, no done
//   data_valid     qualifies data_in
//   data_in        serial data bit
//   busy           high while a run is active
//   match_pulse    one-cycle pulse per detected match
//   match_count    saturating match count of the current/last run
//   done           one-cycle pulse when a bounded window completes
//   cfg_err        one-cycle pulse on a rejected config write or start
module seq_det_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8,
  parameter int WINW   = 16,
  localparam int LENW  = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic [WINW-1:0]   cfg_window,
  input  logic              start,
  input  logic              abort,
  input  logic              data_valid,
  input  logic              data_in,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNTW-1:0]   match_count,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  // Shadow configuration
  logic [MAXLEN-1:0] pattern_q;
  logic [LENW-1:0]   len_q;
  logic              overlap_q;
  logic [WINW-1:0]   window_q;

  // Run datapath
  logic [MAXLEN-1:0] hist_q;
  logic [LENW-1:0]   fill_q;
  logic [WINW-1:0]   bitcnt_q;

  // Combinational decisions
  logic              cfg_load;
  logic              cfg_rej;
  logic              start_ok;
  logic              sample;
  logic              match;
  logic              win_end;
  logic [LENW-1:0]   eff_len;
  logic [MAXLEN-1:0] hist_new;
  logic [LENW-1:0]   fill_inc;
  logic [WINW-1:0]   bitcnt_inc;
  logic [MAXLEN-1:0] len_mask;

  assign hist_new   = {hist_q[MAXLEN-2:0], data_in};
  assign fill_inc   = (fill_q == LENW'(MAXLEN)) ? fill_q : fill_q + 1'b1;
  assign bitcnt_inc = bitcnt_q + 1'b1;

  // Selects the low len_q bits of history and pattern for comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (LENW'(i) < len_q);
    end
  end

  always_comb begin
    state_next = state;
    cfg_load   = 1'b0;
    cfg_rej    = 1'b0;
    start_ok   = 1'b0;
    sample     = 1'b0;
    match      = 1'b0;
    win_end    = 1'b0;
    eff_len    = len_q;
    case (state)
      IDLE: begin
        cfg_load = cfg_we;
        // A start in the same cycle as a config write is judged on the new length.
        eff_len  = cfg_we ? cfg_len : len_q;
        if (start) begin
          if ((eff_len != '0) && (eff_len <= LENW'(MAXLEN))) begin
            start_ok   = 1'b1;
            state_next = RUN;
          end else begin
            cfg_rej = 1'b1;
          end
        end
      end
      RUN: begin
        cfg_rej = cfg_we;
        if (abort) begin
          // Any bit presented alongside abort is dropped.
          state_next = IDLE;
        end else if (data_valid) begin
          sample  = 1'b1;
          match   = (fill_inc >= len_q) &&
                    ((hist_new & len_mask) == (pattern_q & len_mask));
          win_end = (window_q != '0) && (bitcnt_inc == window_q);
          if (win_end) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      window_q  <= '0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
      window_q  <= cfg_window;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q      <= '0;
      fill_q      <= '0;
      bitcnt_q    <= '0;
      match_count <= '0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      match_pulse <= match;
      done        <= win_end;
      cfg_err     <= cfg_rej;
      if (start_ok) begin
        hist_q      <= '0;
        fill_q      <= '0;
        bitcnt_q    <= '0;
        match_count <= '0;
      end else if (sample) begin
        hist_q   <= hist_new;
        bitcnt_q <= bitcnt_inc;
        // Non-overlapping mode forgets every bit used by the match just found.
        fill_q   <= (match && !overlap_q) ? '0 : fill_inc;
        if (match && (match_count != {CNTW{1'b1}})) begin
          match_count <= match_count + 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for a programmable serial pattern detector.
- Holds a configured pattern (1..MAXLEN bits) and an overlap/non-overlap mode.
- Sequences a detection run over a bounded or unbounded window of valid input bits, counting matches.
- Reports completion with a done pulse.
- Sits between the host configuration logic and the serial data stream, replacing fixed hard-coded detectors.

Parameters:
MAXLEN, 8, maximum pattern length in bits.
CNTW, 8, match counter width; counter saturates.
WINW, 16, window length field width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
cfg_we  input  1  load cfg_* fields into shadow registers (IDLE only).
cfg_pattern  input  MAXLEN  pattern; bit[len-1] is the first-arriving bit, bit[0] the last.
cfg_len  input  $clog2(MAXLEN+1)  pattern length; valid range 1..MAXLEN.
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
cfg_window  input  WINW  number of valid bits per run; 0 = unbounded.
start  input  1  begin run (IDLE only).
abort  input  1  terminate run immediately.
data_valid  input  1  data_in qualifier.
data_in  input  1  serial data bit.
busy  output  1  high in RUN.
match_pulse  output  1  one-cycle pulse per detected match.
match_count  output  CNTW  matches in current/last run.
done  output  1  one-cycle pulse when the window completes.
cfg_err  output  1  one-cycle pulse on a rejected config write or start.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; shadow pattern=0, len=0, overlap=0, window=0; history cleared.
- States: IDLE, RUN.
- IDLE:
  - cfg_we loads the shadow registers.
  - start with shadow len in 1..MAXLEN: clears match_count, history shift register, fill count and bit counter; next state RUN.
  - start with shadow len 0 or >MAXLEN: cfg_err pulse; stay IDLE; match_count unchanged.
  - cfg_we and start in the same cycle: config loads first; start is validated against the new values.
- RUN, on each cycle with data_valid=1:
  - Shift data_in into history (LSB = newest).
  - Fill count increments, saturating at MAXLEN.
  - Bit counter increments.
- Match condition: in the same sampling cycle, fill count (including the new bit) >= len and low len bits of history == low len bits of pattern.
- On a match:
  - match_pulse high for the following cycle (registered).
  - match_count increments, saturating at 2^CNTW-1.
  - Overlap=0: fill count resets to 0, so the next match must use entirely new bits.
  - Overlap=1: fill count is retained.
- Window end: when window != 0 and the bit counter reaches window on a valid bit:
  - Next cycle: done=1, busy=0, state IDLE.
  - A match on that final bit pulses match_pulse in the same cycle as done.
- data_valid=0: no state change; gaps of any length are allowed.
- abort in RUN: return to IDLE next cycle; no done; match_count holds its value; a bit sampled in the abort cycle is discarded. abort in IDLE is ignored.
- cfg_we in RUN: ignored; cfg_err pulse; shadow unchanged. start in RUN: ignored, no error.
- match_count holds until the next accepted start.
- Async reset mid-run: immediate return to IDLE with all outputs 0.

Test Plan:
1. Pattern 4'b1010, len 4, overlap 1, window 7, stream 1,0,1,0,1,0,1 (valid every cycle) -> match_pulse after bits 4 and 6; match_count=2; done one cycle after bit 7; busy falls with done.
2. Same as 1 with overlap 0 -> single match after bit 4; match_count=1; done after bit 7.
3. Pattern 3'b110, len 3, window 0, valid asserted every other cycle, stream 1,1,0,1,1,0 -> match_count=2; no done; abort -> busy=0 next cycle; count stays 2; no done pulse.
4. CNTW=2, pattern 1'b1, len 1, window 6, six 1s -> match_count saturates at 3; done asserted.
5. cfg_len=0 then start -> cfg_err pulse, busy stays 0. cfg_we during RUN -> cfg_err pulse; run continues using the old pattern.
6. rst_n low for one cycle mid-run at bit 3 -> busy, match_count, match_pulse, done all 0 immediately; a fresh start after reset uses pattern=0, len=0 -> cfg_err.
